// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM command master.
// Holds the FSM state type, the default timeout and the data bus width.
package avalon_mm_pkg;

    localparam int DATA_W                 = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/avalon_mm_cmd_master.sv
// Single-outstanding command-to-Avalon-MM bridge with timeout and transaction counter.
// Accepts one read/write command, runs it on the bus, then presents one response.
module avalon_mm_cmd_master
    import avalon_mm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0]     CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  AVM_READ,
    output logic                  AVM_WRITE,
    output logic [ADDR_WIDTH-1:0] AVM_ADDR,
    output logic [DATA_W-1:0]     AVM_WRITEDATA,
    input  logic [DATA_W-1:0]     AVM_READDATA,
    input  logic                  AVM_READDATAVALID,
    input  logic                  AVM_WAITREQUEST,
    output logic [15:0]           TXN_COUNT
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  rst_n_int;
    state_e                state_q, state_d;
    logic                  is_write_q, is_write_d;
    logic                  avm_read_q, avm_read_d;
    logic                  avm_write_q, avm_write_d;
    logic [ADDR_WIDTH-1:0] avm_addr_q, avm_addr_d;
    logic [DATA_W-1:0]     avm_wdata_q, avm_wdata_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [15:0]           txn_count_q, txn_count_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [15:0]           tmo_inc;
    logic                  timeout_hit;

    // Reset asserts asynchronously but releases two clocks after RESET_N rises.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign tmo_inc     = tmo_q + 16'd1;
    assign timeout_hit = (tmo_inc == TMO_LIMIT);

    assign CMD_READY     = (state_q == ST_IDLE) && rst_n_int;
    assign RSP_VALID     = (state_q == ST_RESP);
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_ERR       = rsp_err_q;
    assign AVM_READ      = avm_read_q;
    assign AVM_WRITE     = avm_write_q;
    assign AVM_ADDR      = avm_addr_q;
    assign AVM_WRITEDATA = avm_wdata_q;
    assign TXN_COUNT     = txn_count_q;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        avm_read_d  = avm_read_q;
        avm_write_d = avm_write_q;
        avm_addr_d  = avm_addr_q;
        avm_wdata_d = avm_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        txn_count_d = txn_count_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    state_d     = ST_BUS;
                    is_write_d  = CMD_WRITE;
                    avm_addr_d  = CMD_ADDR;
                    avm_wdata_d = CMD_WDATA;
                    avm_write_d = CMD_WRITE;
                    avm_read_d  = !CMD_WRITE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    tmo_d       = '0;
                end
            end
            ST_BUS: begin
                tmo_d = tmo_inc;
                // Timeout wins even if the slave accepts in this same cycle.
                if (timeout_hit) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (!AVM_WAITREQUEST) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (is_write_q) begin
                        state_d = ST_RESP;
                    end else if (AVM_READDATAVALID) begin
                        rsp_rdata_d = AVM_READDATA;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                tmo_d = tmo_inc;
                if (timeout_hit) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (AVM_READDATAVALID) begin
                    rsp_rdata_d = AVM_READDATA;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    txn_count_d = txn_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            avm_addr_q  <= '0;
            avm_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            txn_count_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            avm_read_q  <= avm_read_d;
            avm_write_q <= avm_write_d;
            avm_addr_q  <= avm_addr_d;
            avm_wdata_q <= avm_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            txn_count_q <= txn_count_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Directed and randomized bench for avalon_mm_cmd_master with a cycle-count reference model.
module tb_avalon_mm_cmd_master;

    localparam int T = 8;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [7:0]  CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        AVM_READ;
    logic        AVM_WRITE;
    logic [7:0]  AVM_ADDR;
    logic [31:0] AVM_WRITEDATA;
    logic [31:0] AVM_READDATA;
    logic        AVM_READDATAVALID;
    logic        AVM_WAITREQUEST;
    logic [15:0] TXN_COUNT;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'd0;

    avalon_mm_cmd_master #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_READDATA(AVM_READDATA),
        .AVM_READDATAVALID(AVM_READDATAVALID), .AVM_WAITREQUEST(AVM_WAITREQUEST),
        .TXN_COUNT(TXN_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected timing derives from cycle numbers after accept: the slave accepts in
    // cycle k = wq+1, read data arrives in cycle d = k+rdelay, and anything that
    // would complete in cycle T or later is a timeout responding in cycle T+1.
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input int wq, input int rdelay, input logic [31:0] rdata,
                           input int hold, input bit noise);
        int   k, d, send, rend, resp, guard;
        bit   ok, rdv;
        logic [31:0] rsp_snap;
        @(negedge CLK);
        guard = 0;
        while (!CMD_READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        chk("cmd_ready_before_accept", CMD_READY, 1);
        chk("rsp_valid_before_accept", RSP_VALID, 0);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
        AVM_WAITREQUEST = 1'b0; AVM_READDATAVALID = 1'b0; RSP_READY = 1'b0;
        k = wq + 1;
        d = k + rdelay;
        ok   = wr ? (k <= T - 1) : (d <= T - 1);
        rend = ok ? (wr ? k : d) : T;
        send = (k < T) ? k : T;
        resp = rend + 1;
        rsp_snap = (ok && !wr) ? rdata : 32'h0;
        for (int c = 1; c <= resp + hold; c++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0; CMD_ADDR = 8'($urandom); CMD_WDATA = $urandom;
            chk(wr ? "avm_write_strobe" : "avm_read_strobe", wr ? AVM_WRITE : AVM_READ, (c <= send));
            chk("other_strobe_low", wr ? AVM_READ : AVM_WRITE, 0);
            if (c <= send) begin
                chk("avm_addr_stable", AVM_ADDR, addr);
                if (wr) chk("avm_wdata_stable", AVM_WRITEDATA, wdata);
            end
            chk("rsp_valid_timing", RSP_VALID, (c >= resp));
            chk("cmd_ready_busy", CMD_READY, 0);
            if (c >= resp) begin
                chk("rsp_err", RSP_ERR, !ok);
                chk("rsp_rdata", RSP_RDATA, rsp_snap);
            end
            AVM_WAITREQUEST = (c <= wq);
            rdv = !wr && (c == d);
            if (noise && (wr || c < k)) rdv = 1'($urandom);
            AVM_READDATAVALID = rdv;
            AVM_READDATA = (!wr && c == d) ? rdata : $urandom;
            RSP_READY = (c >= resp + hold);
        end
        exp_cnt++;
        @(negedge CLK);
        chk("rsp_valid_after_handshake", RSP_VALID, 0);
        chk("cmd_ready_after_handshake", CMD_READY, 1);
        chk("txn_count", TXN_COUNT, exp_cnt);
        RSP_READY = 1'b0; AVM_WAITREQUEST = 1'b0;
        AVM_READDATAVALID = 1'b1; AVM_READDATA = $urandom;
        @(negedge CLK);
        chk("idle_beat_no_rsp", RSP_VALID, 0);
        chk("idle_beat_ready", CMD_READY, 1);
        AVM_READDATAVALID = 1'b0;
    endtask

    task automatic reset_in_txn(input int wq);
        int n;
        @(negedge CLK);
        n = 0;
        while (!CMD_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h33; CMD_WDATA = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0;
            AVM_WAITREQUEST = (c <= wq);
            AVM_READDATAVALID = 1'b0;
        end
        chk("read_strobe_before_reset", AVM_READ, (wq >= 3));
        #2 RESET_N = 1'b0;
        #1;
        chk("reset_drops_read", AVM_READ, 0);
        chk("reset_rsp_valid", RSP_VALID, 0);
        chk("reset_cmd_ready", CMD_READY, 0);
        chk("reset_avm_addr", AVM_ADDR, 0);
        chk("reset_txn_count", TXN_COUNT, 0);
        exp_cnt = 16'd0;
        AVM_WAITREQUEST = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        n = 0;
        while (!CMD_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_within_3", (n <= 3), 1);
        chk("no_rsp_after_reset", RSP_VALID, 0);
        chk("txn_count_after_reset", TXN_COUNT, 0);
    endtask

    initial begin
        RESET_N = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 8'h0; CMD_WDATA = 32'h0;
        RSP_READY = 1'b0; AVM_READDATA = 32'h0; AVM_READDATAVALID = 1'b0; AVM_WAITREQUEST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_avm_read", AVM_READ, 0);
        chk("rst_avm_write", AVM_WRITE, 0);
        chk("rst_txn_count", TXN_COUNT, 0);
        chk("rst_rsp_rdata", RSP_RDATA, 0);
        RESET_N = 1'b1;

        run_txn(1'b1, 8'h04, 32'h12345678, 0, 0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 8'h10, 32'h0, 3, 2, 32'hCAFEF00D, 0, 1'b0);
        run_txn(1'b0, 8'h11, 32'h0, 0, 0, 32'h0BADBEEF, 0, 1'b0);
        run_txn(1'b1, 8'h20, 32'hDEADBEEF, 20, 0, 32'h0, 1, 1'b0);
        run_txn(1'b0, 8'h21, 32'h0, 20, 0, 32'h55AA55AA, 1, 1'b0);
        run_txn(1'b0, 8'h22, 32'h0, 2, 10, 32'h11112222, 5, 1'b0);
        run_txn(1'b1, 8'h23, 32'hA5A5A5A5, 6, 0, 32'h0, 0, 1'b0);
        run_txn(1'b1, 8'h24, 32'h5A5A5A5A, 7, 0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 8'h25, 32'h0, 0, 6, 32'h76543210, 0, 1'b0);
        run_txn(1'b0, 8'h26, 32'h0, 0, 7, 32'h89ABCDEF, 0, 1'b0);
        run_txn(1'b0, 8'h27, 32'h0, 1, 1, 32'hFEEDFACE, 5, 1'b0);
        run_txn(1'b1, 8'h28, 32'h01020304, 0, 0, 32'h0, 5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 8)), $urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        reset_in_txn(0);
        reset_in_txn(5);

        @(negedge CLK);
        force dut.txn_count_q = 16'hFFFE;
        #1 release dut.txn_count_q;
        exp_cnt = 16'hFFFE;
        run_txn(1'b1, 8'h40, 32'h1, 0, 0, 32'h0, 0, 1'b0);
        run_txn(1'b1, 8'h41, 32'h2, 0, 0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 8'h42, 32'h0, 0, 0, 32'h33333333, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
